sr_ff_bank: RTL and testbench



---
 rtl/sr_ff_pkg.sv | 35 +++
 rtl/sr_ff_cell.sv | 38 +++
 rtl/sr_ff_bank.sv | 137 +++++++++++++
 tb/tb_sr_ff_bank.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_ff_pkg.sv
// ---------------------------------------------------------------------------
// sr_ff_pkg
// Shared definitions for the sr_ff_bank SR flip-flop bank.
//   CM_HOLD / CM_SET / CM_RST / CM_TOG : next-state actions when S=R=1
//   sr_next()                          : 1-bit next-state function of one channel
// ---------------------------------------------------------------------------
package sr_ff_pkg;

   localparam int CM_HOLD = 0;
   localparam int CM_SET  = 1;
   localparam int CM_RST  = 2;
   localparam int CM_TOG  = 3;

   // Next state of one SR channel that is active this cycle.
   // Any mode code outside 0..3 falls back to hold.
   function automatic logic sr_next(input logic s, input logic r,
                                    input logic q, input int mode);
      logic nxt;
      case ({s, r})
         2'b00:   nxt = q;
         2'b01:   nxt = 1'b0;
         2'b10:   nxt = 1'b1;
         default: begin
            case (mode)
               CM_SET:  nxt = 1'b1;
               CM_RST:  nxt = 1'b0;
               CM_TOG:  nxt = ~q;
               default: nxt = q;
            endcase
         end
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// ---------------------------------------------------------------------------
// sr_ff_cell
// One edge-triggered SR flip-flop channel.
// Parameters:
//   MODE      : action on S=R=1 (CM_HOLD / CM_SET / CM_RST / CM_TOG)
//   RESET_VAL : value loaded into q while rst_n is low
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   active in  channel enabled this cycle (global enable AND channel enable)
//   s, r   in  set / reset requests
//   q      out registered state
// ---------------------------------------------------------------------------
module sr_ff_cell
   import sr_ff_pkg::*;
#(
   parameter int   MODE      = CM_HOLD,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   input  logic s,
   input  logic r,
   output logic q
);

   // NOTE: sequential state is written only with non-blocking assignments so
   // every flop samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RESET_VAL;
      end else if (active) begin
         q <= sr_next(s, r, q, MODE);
      end
   end

endmodule

// File: rtl/sr_ff_bank.sv
// ---------------------------------------------------------------------------
// sr_ff_bank
// WIDTH-channel bank of edge-triggered SR flip-flops with global and
// per-channel enables, elaboration-time S=R=1 policy and conflict monitoring.
//
// Parameters:
//   WIDTH         : number of channels (1..32)
//   CONFLICT_MODE : S=R=1 action, 0 hold / 1 set / 2 reset / 3 toggle;
//                   anything larger behaves as hold
//   CNT_W         : width of the saturating conflict counter
//   RESET_VAL     : value of q during reset
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   en            in   global enable, 0 = every channel holds
//   ch_en[W]      in   per-channel enable mask
//   s[W], r[W]    in   per-channel set / reset
//   clr           in   synchronous clear of conflict_cnt and conflict
//   q[W]          out  registered state
//   qb[W]         out  ~q
//   conflict      out  sticky flag, some active channel saw S=R=1
//   conflict_cnt  out  saturating count of conflict cycles
// Optional (macro SR_FF_EDGE_PULSE_EN defined):
//   q_rise[W]     out  one-cycle registered pulse after q[i] went 0->1
//   q_fall[W]     out  one-cycle registered pulse after q[i] went 1->0
// ---------------------------------------------------------------------------
module sr_ff_bank
   import sr_ff_pkg::*;
#(
   parameter int               WIDTH         = 8,
   parameter int               CONFLICT_MODE = 0,
   parameter int               CNT_W         = 8,
   parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] ch_en,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   input  logic             clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic             conflict,
   output logic [CNT_W-1:0] conflict_cnt
`ifdef SR_FF_EDGE_PULSE_EN
   ,
   output logic [WIDTH-1:0] q_rise,
   output logic [WIDTH-1:0] q_fall
`endif
);

   // Out-of-range mode codes degrade to hold rather than undefined behaviour.
   localparam int EFF_MODE = (CONFLICT_MODE > CM_TOG || CONFLICT_MODE < 0)
                             ? CM_HOLD : CONFLICT_MODE;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   generate
      if (CONFLICT_MODE > CM_TOG || CONFLICT_MODE < 0) begin : g_bad_mode
         always_comb begin
            assert (CONFLICT_MODE <= CM_TOG && CONFLICT_MODE >= 0)
               else $error("sr_ff_bank: CONFLICT_MODE %0d illegal, using hold",
                           CONFLICT_MODE);
         end
      end
   endgenerate

   logic [WIDTH-1:0] active;
   logic             conf_now;

   assign active   = ch_en & {WIDTH{en}};
   // One event per cycle no matter how many channels collide.
   assign conf_now = |(active & s & r);

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      sr_ff_cell #(
         .MODE      (EFF_MODE),
         .RESET_VAL (RESET_VAL[i])
      ) u_cell (
         .clk    (clk),
         .rst_n  (rst_n),
         .active (active[i]),
         .s      (s[i]),
         .r      (r[i]),
         .q      (q[i])
      );
   end

   // Derived from q combinationally so it follows q through reset as well.
   assign qb = ~q;

   // A conflict arriving together with clr wins: the window restarts at one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_cnt <= '0;
         conflict     <= 1'b0;
      end else if (clr) begin
         conflict_cnt <= conf_now ? CNT_ONE : '0;
         conflict     <= conf_now;
      end else if (conf_now) begin
         if (conflict_cnt != CNT_MAX) begin
            conflict_cnt <= conflict_cnt + CNT_ONE;
         end
         conflict <= 1'b1;
      end
   end

`ifdef SR_FF_EDGE_PULSE_EN
   // Recompute each channel's next state so the pulses can be registered on
   // the same edge that updates q.
   logic [WIDTH-1:0] q_nxt;

   // NOTE: every combinational output gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      q_nxt = q;
      for (int i = 0; i < WIDTH; i++) begin
         if (active[i]) begin
            q_nxt[i] = sr_next(s[i], r[i], q[i], EFF_MODE);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_rise <= '0;
         q_fall <= '0;
      end else begin
         q_rise <= q_nxt & ~q;
         q_fall <= ~q_nxt & q;
      end
   end
`endif

endmodule

// File: tb/tb_sr_ff_bank.sv
// ---------------------------------------------------------------------------
// tb_sr_ff_bank
// Directed bench for sr_ff_bank. Four copies share one stimulus stream, one
// per CONFLICT_MODE; copy 0 also uses CNT_W=2 to reach counter saturation.
// Edge-pulse outputs are checked when SR_FF_EDGE_PULSE_EN is defined.
// ---------------------------------------------------------------------------
module tb_sr_ff_bank;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] ch_en;
   logic [7:0] s;
   logic [7:0] r;
   logic       clr;

   logic [7:0] q_o   [4];
   logic [7:0] qb_o  [4];
   logic       cf_o  [4];
   logic [1:0] cnt0;
   logic [7:0] cnt8  [3];
`ifdef SR_FF_EDGE_PULSE_EN
   logic [7:0] rise_o [4];
   logic [7:0] fall_o [4];
`endif

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   sr_ff_bank #(
      .WIDTH         (8),
      .CONFLICT_MODE (0),
      .CNT_W         (2),
      .RESET_VAL     (8'hA5)
   ) u_m0 (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .ch_en        (ch_en),
      .s            (s),
      .r            (r),
      .clr          (clr),
      .q            (q_o[0]),
      .qb           (qb_o[0]),
      .conflict     (cf_o[0]),
      .conflict_cnt (cnt0)
`ifdef SR_FF_EDGE_PULSE_EN
      ,
      .q_rise       (rise_o[0]),
      .q_fall       (fall_o[0])
`endif
   );

   for (genvar m = 1; m < 4; m++) begin : g_dut
      sr_ff_bank #(
         .WIDTH         (8),
         .CONFLICT_MODE (m),
         .CNT_W         (8),
         .RESET_VAL     (8'hA5)
      ) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .en           (en),
         .ch_en        (ch_en),
         .s            (s),
         .r            (r),
         .clr          (clr),
         .q            (q_o[m]),
         .qb           (qb_o[m]),
         .conflict     (cf_o[m]),
         .conflict_cnt (cnt8[m-1])
`ifdef SR_FF_EDGE_PULSE_EN
         ,
         .q_rise       (rise_o[m]),
         .q_fall       (fall_o[m])
`endif
      );
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // q and qb of all four copies (hold / set / reset / toggle).
   task automatic check_q(input string tag, input logic [7:0] e0,
                          input logic [7:0] e1, input logic [7:0] e2,
                          input logic [7:0] e3);
      logic [7:0] e [4];
      e = '{e0, e1, e2, e3};
      for (int m = 0; m < 4; m++) begin
         check($sformatf("%s.q%0d", tag, m),  {24'h0, q_o[m]},  {24'h0, e[m]});
         check($sformatf("%s.qb%0d", tag, m), {24'h0, qb_o[m]}, {24'h0, ~e[m]});
      end
   endtask

   // Counter of copy 0 (2-bit), counters of copies 1..3, sticky flag of all.
   task automatic check_cnt(input string tag, input logic [1:0] e_c0,
                            input logic [7:0] e_c8, input logic e_cf);
      check($sformatf("%s.cnt0", tag), {30'h0, cnt0}, {30'h0, e_c0});
      for (int m = 0; m < 3; m++) begin
         check($sformatf("%s.cnt%0d", tag, m + 1), {24'h0, cnt8[m]}, {24'h0, e_c8});
      end
      for (int m = 0; m < 4; m++) begin
         check($sformatf("%s.conflict%0d", tag, m), {31'h0, cf_o[m]}, {31'h0, e_cf});
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] m3_exp  [4];
      logic [1:0] cnt0_exp[4];
      m3_exp   = '{8'h0F, 8'h0E, 8'h0F, 8'h0E};
      cnt0_exp = '{2'd1, 2'd2, 2'd3, 2'd3};

      rst_n = 1'b1;
      en    = 1'b0;
      ch_en = 8'h00;
      s     = 8'h00;
      r     = 8'h00;
      clr   = 1'b0;

      // Asynchronous reset before the first clock edge.
      #2 rst_n = 1'b0;
      #1;
      check_q("async_reset", 8'hA5, 8'hA5, 8'hA5, 8'hA5);
      check_cnt("async_reset", 2'd0, 8'd0, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;
      step();
      check_q("after_release", 8'hA5, 8'hA5, 8'hA5, 8'hA5);

      // Global enable low: set requests on every channel are ignored.
      en = 1'b0; ch_en = 8'hFF; s = 8'hFF; r = 8'h00;
      for (int k = 0; k < 3; k++) begin
         step();
         check_q($sformatf("gate_off%0d", k), 8'hA5, 8'hA5, 8'hA5, 8'hA5);
      end

      // Only the low nibble is enabled: (A5 & F0) | 0F.
      en = 1'b1; ch_en = 8'h0F;
      step();
      check_q("gate_nibble", 8'hAF, 8'hAF, 8'hAF, 8'hAF);

      // Reset the high nibble.
      ch_en = 8'hFF; s = 8'h00; r = 8'hF0;
      step();
      check_q("reset_hi", 8'h0F, 8'h0F, 8'h0F, 8'h0F);

      // 00 holds.
      r = 8'h00;
      step();
      check_q("hold00", 8'h0F, 8'h0F, 8'h0F, 8'h0F);
      check_cnt("no_conflict_yet", 2'd0, 8'd0, 1'b0);

      // Clear channel 0 ahead of the mode sequence.
      ch_en = 8'h01; r = 8'h01;
      step();
      check_q("clear_ch0", 8'h0E, 8'h0E, 8'h0E, 8'h0E);

      // S=R=1 on channel 0 for four cycles.
      s = 8'h01; r = 8'h01;
      for (int k = 0; k < 4; k++) begin
         step();
         check_q($sformatf("mode_cyc%0d", k), 8'h0E, 8'h0F, 8'h0E, m3_exp[k]);
         check_cnt($sformatf("mode_cyc%0d", k), cnt0_exp[k], 8'(k + 1), 1'b1);
      end

      // clr without a conflict.
      clr = 1'b1; ch_en = 8'hFF; s = 8'h00; r = 8'h00;
      step();
      check_cnt("clr_plain", 2'd0, 8'd0, 1'b0);
      check_q("clr_plain", 8'h0E, 8'h0F, 8'h0E, 8'h0E);

      // Three channels collide in one cycle: counter steps once.
      clr = 1'b0; ch_en = 8'h07; s = 8'h07; r = 8'h07;
      step();
      check_q("multi_conf", 8'h0E, 8'h0F, 8'h08, 8'h09);
      check_cnt("multi_conf", 2'd1, 8'd1, 1'b1);

      // Colliding channels that are masked do not count.
      ch_en = 8'h0F; s = 8'hF0; r = 8'hF0;
      step();
      check_cnt("masked_conf", 2'd1, 8'd1, 1'b1);
      check_q("masked_conf", 8'h0E, 8'h0F, 8'h08, 8'h09);

      en = 1'b0; ch_en = 8'hFF; s = 8'hFF; r = 8'hFF;
      step();
      check_cnt("gated_conf", 2'd1, 8'd1, 1'b1);
      check_q("gated_conf", 8'h0E, 8'h0F, 8'h08, 8'h09);

      // clr together with a conflict: the new event wins.
      en = 1'b1; clr = 1'b1; ch_en = 8'h01; s = 8'h01; r = 8'h01;
      step();
      check_cnt("clr_with_conf", 2'd1, 8'd1, 1'b1);
      check_q("clr_with_conf", 8'h0E, 8'h0F, 8'h08, 8'h08);

      // Five more conflict cycles: the 2-bit counter pins at 3.
      clr = 1'b0;
      for (int k = 0; k < 5; k++) step();
      check_cnt("saturate", 2'd3, 8'd6, 1'b1);
      check_q("saturate", 8'h0E, 8'h0F, 8'h08, 8'h09);

      // Reset mid-operation, checked before the next edge.
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_q("mid_reset", 8'hA5, 8'hA5, 8'hA5, 8'hA5);
      check_cnt("mid_reset", 2'd0, 8'd0, 1'b0);

      s = 8'h00; r = 8'h00; ch_en = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check_q("mid_release", 8'hA5, 8'hA5, 8'hA5, 8'hA5);
      check_cnt("mid_release", 2'd0, 8'd0, 1'b0);

`ifdef SR_FF_EDGE_PULSE_EN
      // Channel 3 rises once.
      ch_en = 8'h08; s = 8'h08; r = 8'h00;
      step();
      check_q("rise3", 8'hAD, 8'hAD, 8'hAD, 8'hAD);
      for (int m = 0; m < 4; m++) begin
         check($sformatf("rise3.q_rise%0d", m), {24'h0, rise_o[m]}, 32'h08);
         check($sformatf("rise3.q_fall%0d", m), {24'h0, fall_o[m]}, 32'h00);
      end
      s = 8'h00;
      step();
      for (int m = 0; m < 4; m++) begin
         check($sformatf("rise3_end.q_rise%0d", m), {24'h0, rise_o[m]}, 32'h00);
      end

      // Toggle copy alternates fall / rise / fall on channel 0 (starts at 1).
      ch_en = 8'h01; s = 8'h01; r = 8'h01;
      step();
      check("tog0.fall3", {24'h0, fall_o[3]}, 32'h01);
      check("tog0.rise3", {24'h0, rise_o[3]}, 32'h00);
      check("tog0.fall1", {24'h0, fall_o[1]}, 32'h00);
      step();
      check("tog1.rise3", {24'h0, rise_o[3]}, 32'h01);
      check("tog1.fall3", {24'h0, fall_o[3]}, 32'h00);
      check("tog1.rise1", {24'h0, rise_o[1]}, 32'h00);
      step();
      check("tog2.fall3", {24'h0, fall_o[3]}, 32'h01);
      check("tog2.rise3", {24'h0, rise_o[3]}, 32'h00);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
